ysyx_22051013_fetch_ctrl: RTL and testbench

Fetch-stage sequencer. It owns the architectural fetch PC and issues one instruction-memory request at a time over a req/ready + rsp_valid interface. It buffers the returned instruction until decode accepts it and discards stale responses after redirects. It sits between the already prioritised next-PC redirect selection (execute > LSU > decode) with the BPU, and the IF/ID stage register.

---
 rtl/ysyx_22051013_fetch_ctrl_if.sv | 34 +++
 rtl/ysyx_22051013_fetch_ctrl.sv | 92 +++++++++
 tb/tb_ysyx_22051013_fetch_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22051013_fetch_ctrl_if.sv
// Fetch-stage bundle: redirect/BPU inputs, instruction-memory req/rsp, IF/ID handoff.
// master = fetch controller side, slave = surrounding pipeline and memory.
interface ysyx_22051013_fetch_ctrl_if #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
);
    logic              redirect_i;
    logic [PC_W-1:0]   redirect_pc_i;
    logic [PC_W-1:0]   pred_pc_i;
    logic [PC_W-1:0]   fetch_pc_o;
    logic              imem_req_valid_o;
    logic [PC_W-1:0]   imem_req_addr_o;
    logic              imem_req_ready_i;
    logic              imem_rsp_valid_i;
    logic [INST_W-1:0] imem_rsp_inst_i;
    logic              if_valid_o;
    logic [PC_W-1:0]   if_pc_o;
    logic [INST_W-1:0] if_inst_o;
    logic              id_ready_i;

    modport master (
        input  redirect_i, redirect_pc_i, pred_pc_i,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_inst_i, id_ready_i,
        output fetch_pc_o, imem_req_valid_o, imem_req_addr_o,
        output if_valid_o, if_pc_o, if_inst_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, pred_pc_i,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_inst_i, id_ready_i,
        input  fetch_pc_o, imem_req_valid_o, imem_req_addr_o,
        input  if_valid_o, if_pc_o, if_inst_o
    );
endinterface

// File: rtl/ysyx_22051013_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, one imem request in flight, buffers the returned instruction.
// Latency: instruction presented to decode the cycle after rsp_valid; best case 1 inst / 3 cycles.
// Backpressure: id_ready low holds the buffered instruction; no new request until decode accepts.
module ysyx_22051013_fetch_ctrl #(
    parameter int               PC_W     = 64,
    parameter int               INST_W   = 32,
    parameter logic [PC_W-1:0]  RESET_PC = 64'h8000_0000
) (
    input  logic                             clk,
    input  logic                             rst,
    ysyx_22051013_fetch_ctrl_if.master       bus
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [PC_W-1:0]     pc, pc_nxt;
    logic [INST_W-1:0]   inst_buf, inst_buf_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            inst_buf <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            inst_buf <= inst_buf_nxt;
        end
    end

    // Redirect always wins over capturing a response or handing off to decode.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        inst_buf_nxt = inst_buf;
        case (state)
            S_REQ: begin
                if (bus.redirect_i)
                    pc_nxt = bus.redirect_pc_i;
                if (bus.imem_req_ready_i)
                    state_nxt = bus.redirect_i ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid_i) begin
                    if (bus.redirect_i) begin
                        pc_nxt    = bus.redirect_pc_i;
                        state_nxt = S_REQ;
                    end else begin
                        inst_buf_nxt = bus.imem_rsp_inst_i;
                        state_nxt    = S_HOLD;
                    end
                end else if (bus.redirect_i) begin
                    pc_nxt    = bus.redirect_pc_i;
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The response arriving here belongs to an abandoned PC.
                if (bus.redirect_i)
                    pc_nxt = bus.redirect_pc_i;
                if (bus.imem_rsp_valid_i)
                    state_nxt = S_REQ;
            end
            S_HOLD: begin
                if (bus.redirect_i) begin
                    pc_nxt    = bus.redirect_pc_i;
                    state_nxt = S_REQ;
                end else if (bus.id_ready_i) begin
                    pc_nxt    = bus.pred_pc_i;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        bus.fetch_pc_o       = pc;
        bus.imem_req_addr_o  = pc;
        bus.if_pc_o          = pc;
        bus.imem_req_valid_o = (state == S_REQ);
        bus.if_valid_o       = (state == S_HOLD) && !bus.redirect_i;
        bus.if_inst_o        = inst_buf;
    end

endmodule

// File: tb/tb_ysyx_22051013_fetch_ctrl.sv
// Bench for the fetch sequencer: directed scenarios plus a randomized run against a
// transaction-level model (outstanding/stale/buffered flags) with a latency-randomized memory.
module tb_ysyx_22051013_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ysyx_22051013_fetch_ctrl_if #(.PC_W(64), .INST_W(32)) bus ();

    ysyx_22051013_fetch_ctrl #(
        .PC_W(64), .INST_W(32), .RESET_PC(64'h8000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Apply inputs (called just after a negedge) and let combinational outputs settle.
    task automatic drive(input bit rd, input logic [63:0] rpc, input logic [63:0] pp,
                         input bit rr, input bit rv, input logic [31:0] ri, input bit idr);
        bus.redirect_i       = rd;
        bus.redirect_pc_i    = rpc;
        bus.pred_pc_i        = pp;
        bus.imem_req_ready_i = rr;
        bus.imem_rsp_valid_i = rv;
        bus.imem_rsp_inst_i  = ri;
        bus.id_ready_i       = idr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 64'h0, 64'h0, 0, 0, 32'h0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Take a fresh REQ through acceptance and a 1-cycle response into HOLD.
    task automatic fetch_into_hold(input logic [31:0] inst);
        drive(0, 64'h0, 64'h0, 1, 0, 32'h0, 0);
        tick();
        drive(0, 64'h0, 64'h0, 0, 1, inst, 0);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 64'h0, 64'h0, 0, 0, 32'h0, 0);
        tick();
        checks++; if (bus.imem_req_valid_o !== 1'b1) begin errors++; $display("FAIL reset_req_valid got %0b want 1", bus.imem_req_valid_o); end
        checks++; if (bus.imem_req_addr_o !== 64'h8000_0000) begin errors++; $display("FAIL reset_addr got %h want 80000000", bus.imem_req_addr_o); end
        checks++; if (bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %0b want 0", bus.if_valid_o); end
        checks++; if (bus.if_inst_o !== 32'h0) begin errors++; $display("FAIL reset_if_inst got %h want 0", bus.if_inst_o); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        drive(0, 64'h0, 64'h0, 1, 0, 32'h0, 0);
        checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 64'h8000_0000) begin errors++; $display("FAIL basic_first_req got v=%0b a=%h want v=1 a=80000000", bus.imem_req_valid_o, bus.imem_req_addr_o); end
        checks++; if (bus.fetch_pc_o !== 64'h8000_0000) begin errors++; $display("FAIL basic_fetch_pc got %h want 80000000", bus.fetch_pc_o); end
        tick();
        drive(0, 64'h0, 64'h0, 0, 1, 32'h0000_0513, 0);
        checks++; if (bus.imem_req_valid_o !== 1'b0 || bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL basic_wait got req=%0b ifv=%0b want 0 0", bus.imem_req_valid_o, bus.if_valid_o); end
        tick();
        drive(0, 64'h0, 64'h8000_0004, 0, 0, 32'h0, 1);
        checks++; if (bus.if_valid_o !== 1'b1) begin errors++; $display("FAIL basic_if_valid got %0b want 1", bus.if_valid_o); end
        checks++; if (bus.if_pc_o !== 64'h8000_0000) begin errors++; $display("FAIL basic_if_pc got %h want 80000000", bus.if_pc_o); end
        checks++; if (bus.if_inst_o !== 32'h0000_0513) begin errors++; $display("FAIL basic_if_inst got %h want 00000513", bus.if_inst_o); end
        tick();
        drive(0, 64'h0, 64'h0, 0, 0, 32'h0, 0);
        checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 64'h8000_0004) begin errors++; $display("FAIL basic_next_req got v=%0b a=%h want v=1 a=80000004", bus.imem_req_valid_o, bus.imem_req_addr_o); end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_into_hold(32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            drive(0, 64'h0, 64'h8000_0008, 0, 0, 32'h0, 0);
            checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 64'h8000_0000 || bus.if_inst_o !== 32'h1234_5678 || bus.imem_req_valid_o !== 1'b0)
                begin errors++; $display("FAIL bp_hold cyc=%0d got ifv=%0b pc=%h inst=%h req=%0b want 1 80000000 12345678 0", i, bus.if_valid_o, bus.if_pc_o, bus.if_inst_o, bus.imem_req_valid_o); end
            tick();
        end
        drive(0, 64'h0, 64'h8000_0008, 0, 0, 32'h0, 1);
        tick();
        drive(0, 64'h0, 64'h0, 0, 0, 32'h0, 0);
        checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 64'h8000_0008) begin errors++; $display("FAIL bp_release got v=%0b a=%h want v=1 a=80000008", bus.imem_req_valid_o, bus.imem_req_addr_o); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        drive(0, 64'h0, 64'h0, 1, 0, 32'h0, 0);
        tick();
        drive(1, 64'h8000_0100, 64'h0, 0, 0, 32'h0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 64'h0, 64'h0, 1, 0, 32'h0, 1);
            checks++; if (bus.imem_req_valid_o !== 1'b0 || bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL rw_drain cyc=%0d got req=%0b ifv=%0b want 0 0", i, bus.imem_req_valid_o, bus.if_valid_o); end
            tick();
        end
        drive(0, 64'h0, 64'h0, 0, 1, 32'hDEAD_BEEF, 1);
        tick();
        drive(0, 64'h0, 64'h0, 1, 0, 32'h0, 0);
        checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 64'h8000_0100) begin errors++; $display("FAIL rw_next_req got v=%0b a=%h want v=1 a=80000100", bus.imem_req_valid_o, bus.imem_req_addr_o); end
        checks++; if (bus.if_valid_o !== 1'b0 || bus.if_inst_o === 32'hDEAD_BEEF) begin errors++; $display("FAIL rw_stale got ifv=%0b inst=%h want ifv=0 and not deadbeef", bus.if_valid_o, bus.if_inst_o); end
        tick();
        drive(0, 64'h0, 64'h0, 0, 1, 32'h0000_0011, 0);
        tick();
        drive(0, 64'h0, 64'h0, 0, 0, 32'h0, 0);
        checks++; if (bus.if_valid_o !== 1'b1 || bus.if_inst_o !== 32'h0000_0011 || bus.if_pc_o !== 64'h8000_0100) begin errors++; $display("FAIL rw_refetch got ifv=%0b inst=%h pc=%h want 1 00000011 80000100", bus.if_valid_o, bus.if_inst_o, bus.if_pc_o); end
    endtask

    task automatic test_redirect_rsp();
        do_reset();
        drive(0, 64'h0, 64'h0, 1, 0, 32'h0, 0);
        tick();
        drive(1, 64'h8000_0300, 64'h0, 0, 1, 32'h0000_0BAD, 0);
        checks++; if (bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL rr_ifv got %0b want 0", bus.if_valid_o); end
        tick();
        drive(0, 64'h0, 64'h0, 0, 0, 32'h0, 0);
        checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 64'h8000_0300) begin errors++; $display("FAIL rr_req got v=%0b a=%h want v=1 a=80000300", bus.imem_req_valid_o, bus.imem_req_addr_o); end
        checks++; if (bus.if_inst_o === 32'h0000_0BAD) begin errors++; $display("FAIL rr_dropped got inst=%h want not 00000bad", bus.if_inst_o); end
    endtask

    task automatic test_redirect_req_drain();
        do_reset();
        drive(1, 64'h8000_0100, 64'h0, 1, 0, 32'h0, 0);
        tick();
        drive(1, 64'h8000_0200, 64'h0, 1, 0, 32'h0, 0);
        checks++; if (bus.imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rq_drain got req=%0b want 0", bus.imem_req_valid_o); end
        tick();
        drive(0, 64'h0, 64'h0, 1, 1, 32'hDEAD_BEEF, 1);
        checks++; if (bus.imem_req_valid_o !== 1'b0 || bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL rq_drain2 got req=%0b ifv=%0b want 0 0", bus.imem_req_valid_o, bus.if_valid_o); end
        tick();
        drive(0, 64'h0, 64'h0, 0, 0, 32'h0, 0);
        checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 64'h8000_0200) begin errors++; $display("FAIL rq_next_req got v=%0b a=%h want v=1 a=80000200", bus.imem_req_valid_o, bus.imem_req_addr_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 64'h9000_0000, 64'h0, 1, 0, 32'h0, 0);
        tick();
        drive(0, 64'h0, 64'h0, 0, 0, 32'h0, 0);
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 64'h8000_0000 || bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL ar_wait got req=%0b a=%h ifv=%0b want 1 80000000 0", bus.imem_req_valid_o, bus.imem_req_addr_o, bus.if_valid_o); end
        tick();
        rst = 1'b0;
        drive(0, 64'h0, 64'h0, 1, 0, 32'h0, 0);
        tick();
        drive(0, 64'h0, 64'h0, 0, 1, 32'h0000_0777, 0);
        tick();
        drive(0, 64'h0, 64'h0, 0, 0, 32'h0, 0);
        checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 64'h8000_0000 || bus.if_inst_o !== 32'h0000_0777) begin errors++; $display("FAIL ar_restart got ifv=%0b pc=%h inst=%h want 1 80000000 00000777", bus.if_valid_o, bus.if_pc_o, bus.if_inst_o); end
        drive(0, 64'h0, 64'h0, 0, 0, 32'h0, 0);
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 64'h8000_0000 || bus.if_valid_o !== 1'b0 || bus.if_inst_o !== 32'h0) begin errors++; $display("FAIL ar_hold got req=%0b a=%h ifv=%0b inst=%h want 1 80000000 0 0", bus.imem_req_valid_o, bus.imem_req_addr_o, bus.if_valid_o, bus.if_inst_o); end
        tick();
        rst = 1'b0;
    endtask

    // Model view: a request may issue only when nothing is outstanding and nothing is buffered;
    // an outstanding request is marked stale once its PC has been redirected away.
    task automatic test_random();
        bit          m_out, m_stale, m_buf, mem_busy;
        logic [63:0] m_pc;
        logic [31:0] m_inst;
        int          mem_cnt;
        bit          rd, rr, rv, idr, exp_req, exp_ifv;
        logic [63:0] rpc, pp;
        logic [31:0] ri;
        do_reset();
        m_out = 0; m_stale = 0; m_buf = 0; m_pc = 64'h8000_0000; m_inst = 32'h0;
        mem_busy = 0; mem_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rd  = ($urandom % 6) == 0;
            rpc = {$urandom, $urandom};
            pp  = {$urandom, $urandom};
            rr  = ($urandom % 2) == 1;
            rv  = mem_busy && (mem_cnt == 0);
            ri  = $urandom;
            idr = ($urandom % 3) != 0;
            exp_req = !m_out && !m_buf;
            exp_ifv = m_buf && !rd;
            drive(rd, rpc, pp, rr, rv, ri, idr);
            checks++; if (bus.imem_req_valid_o !== exp_req) begin errors++; $display("FAIL rnd_req_valid cyc=%0d got %0b want %0b", cyc, bus.imem_req_valid_o, exp_req); end
            checks++; if (bus.imem_req_addr_o !== m_pc || bus.fetch_pc_o !== m_pc || bus.if_pc_o !== m_pc) begin errors++; $display("FAIL rnd_pc cyc=%0d got %h/%h/%h want %h", cyc, bus.imem_req_addr_o, bus.fetch_pc_o, bus.if_pc_o, m_pc); end
            checks++; if (bus.if_valid_o !== exp_ifv) begin errors++; $display("FAIL rnd_if_valid cyc=%0d got %0b want %0b", cyc, bus.if_valid_o, exp_ifv); end
            checks++; if (bus.if_inst_o !== m_inst) begin errors++; $display("FAIL rnd_if_inst cyc=%0d got %h want %h", cyc, bus.if_inst_o, m_inst); end
            tick();
            if (rv) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (exp_req && rr) begin mem_busy = 1; mem_cnt = $urandom_range(0, 2); end
            if (m_buf) begin
                if (rd) begin m_pc = rpc; m_buf = 0; end
                else if (idr) begin m_pc = pp; m_buf = 0; end
            end else if (!m_out) begin
                if (rr) begin m_out = 1; m_stale = rd; end
                if (rd) m_pc = rpc;
            end else begin
                if (rv) begin
                    m_out = 0;
                    if (!m_stale && !rd) begin m_buf = 1; m_inst = ri; end
                end else if (rd) m_stale = 1;
                if (rd) m_pc = rpc;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp();
        test_redirect_req_drain();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
